// File: rtl/sobel_pkg.sv
// Shared widths, constants and the border test for the streaming Sobel edge detector.
package sobel_pkg;

    localparam int GRAD_EXTRA      = 3;
    localparam int DEFAULT_PIXEL_W = 8;

    typedef logic signed [DEFAULT_PIXEL_W+GRAD_EXTRA-1:0] grad_t;
    typedef logic        [DEFAULT_PIXEL_W+GRAD_EXTRA-1:0] mag_t;

    function automatic int grad_width(input int pixel_w);
        return pixel_w + GRAD_EXTRA;
    endfunction

    // The first two rows and columns of a frame see a window that still holds stale pixels.
    function automatic logic is_border(input int unsigned row, input int unsigned col);
        return (row < 2) || (col < 2);
    endfunction

endpackage

// File: rtl/sobel_linebuf.sv
// Single-port line buffer: combinational read of the addressed word, write on enable.
module sobel_linebuf
    import sobel_pkg::*;
#(
    parameter int DEPTH = 352,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read returns the old word even in the cycle it is overwritten.
    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector with two line buffers and a three-stage pipeline.
// Define SOBEL_THRESH_EN to output a binary edge map (mag > THRESH) instead of saturated magnitude.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int PIXEL_W = 8,
    parameter int IMG_W   = 352,
    parameter int IMG_H   = 288,
    parameter int THRESH  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIXEL_W-1:0] in_pixel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [PIXEL_W-1:0] out_pixel,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int GW    = grad_width(PIXEL_W);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic               adv;
    logic               xfer;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [PIXEL_W-1:0] lb0_rd;
    logic [PIXEL_W-1:0] lb1_rd;
    logic [PIXEL_W-1:0] win [3][3];

    logic               s1_valid;
    logic               s1_border;
    logic               s2_valid;
    logic               s2_border;
    logic signed [GW-1:0] gx_c;
    logic signed [GW-1:0] gy_c;
    logic signed [GW-1:0] gx_q;
    logic signed [GW-1:0] gy_q;
    logic [GW-1:0]      abs_gx;
    logic [GW-1:0]      abs_gy;
    logic [GW-1:0]      mag_c;
    logic [PIXEL_W-1:0] pix_c;

    // One stall signal freezes the whole pipeline, counters and line buffers together.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign xfer     = in_valid && adv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (xfer) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    sobel_linebuf #(
        .DEPTH (IMG_W),
        .WIDTH (PIXEL_W)
    ) u_lb0 (
        .clk     (clk),
        .en      (xfer),
        .addr    (col),
        .wr_data (in_pixel),
        .rd_data (lb0_rd)
    );

    sobel_linebuf #(
        .DEPTH (IMG_W),
        .WIDTH (PIXEL_W)
    ) u_lb1 (
        .clk     (clk),
        .en      (xfer),
        .addr    (col),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // Window rows are top..bottom, columns oldest..newest; w[2][2] is the pixel just accepted.
    always_ff @(posedge clk) begin
        if (xfer) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1_rd;
            win[1][2] <= lb0_rd;
            win[2][2] <= in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_border <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_border <= is_border(32'(row), 32'(col));
        end
    end

    function automatic logic [GW-1:0] wsum(input logic [PIXEL_W-1:0] a,
                                           input logic [PIXEL_W-1:0] b,
                                           input logic [PIXEL_W-1:0] c);
        return GW'(a) + (GW'(b) << 1) + GW'(c);
    endfunction

    // Weighted sums never exceed 4*(2^PIXEL_W-1), so the difference fits the signed width.
    always_comb begin
        gx_c = wsum(win[0][2], win[1][2], win[2][2]) - wsum(win[0][0], win[1][0], win[2][0]);
        gy_c = wsum(win[2][0], win[2][1], win[2][2]) - wsum(win[0][0], win[0][1], win[0][2]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_border <= 1'b0;
            gx_q      <= '0;
            gy_q      <= '0;
        end else if (adv) begin
            s2_valid  <= s1_valid;
            s2_border <= s1_border;
            gx_q      <= gx_c;
            gy_q      <= gy_c;
        end
    end

    always_comb begin
        abs_gx = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
        abs_gy = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
        mag_c  = abs_gx + abs_gy;
    end

`ifdef SOBEL_THRESH_EN
    localparam logic [GW-1:0] THRESH_V = GW'(THRESH);

    always_comb begin
        pix_c = (mag_c > THRESH_V) ? '1 : '0;
    end
`else
    always_comb begin
        pix_c = (|mag_c[GW-1:PIXEL_W]) ? '1 : mag_c[PIXEL_W-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            out_pixel <= s2_border ? '0 : pix_c;
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream on an 8x4 frame: step patterns, saturation, stalls, bubbles, mid-frame reset.
module tb_sobel_stream;

    localparam int PW = 8;
    localparam int W  = 8;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] in_pixel;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] out_pixel;
    logic          out_valid;
    logic          out_ready;

    always #5 clk = ~clk;

    sobel_stream #(
        .PIXEL_W (PW),
        .IMG_W   (W),
        .IMG_H   (H),
        .THRESH  (50)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_pixel  (in_pixel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_pixel (out_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Frame is a (column or row) step from a to b; mag is the hand-computed magnitude at
    // the columns set in mask for rows 2 and 3, every other output is 0.
    typedef struct packed {
        logic        row_step;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] mag;
        logic [7:0]  mask;
    } vec_t;

    vec_t       vecs [7];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         out_count = 0;
    int         first_xfer_edge = -1;
    int         first_valid_edge = -1;
    logic [7:0] expq [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic logic [7:0] expOut(input int mag);
`ifdef SOBEL_THRESH_EN
        return (mag > 50) ? 8'hFF : 8'h00;
`else
        return (mag > 255) ? 8'hFF : 8'(mag);
`endif
    endfunction

    // Inputs change at posedge+2, everything is sampled at the negedge before the next edge.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (first_valid_edge < 0) first_valid_edge = cyc;
            if (expq.size() == 0) begin
                checkOutput("unexpected out_valid", 1, 0);
            end else begin
                checkOutput($sformatf("out_pixel #%0d", out_count), out_pixel, expq[0]);
                if (out_ready) begin
                    void'(expq.pop_front());
                    out_count++;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] pix, input logic [7:0] want);
        int   waited;
        logic acc;
        waited    = 0;
        acc       = 1'b0;
        in_pixel  = pix;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (!acc && waited < 100) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                expq.push_back(want);
                if (first_xfer_edge < 0) first_xfer_edge = cyc + 1;
            end
            @(posedge clk);
            #2;
            waited++;
        end
        if (!acc) checkOutput("accept timeout", 0, 1);
    endtask

    task automatic stallCycles(input logic [7:0] pix, input int n);
        in_pixel  = pix;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        repeat (n) begin
            @(negedge clk);
            checkOutput("in_ready during stall", in_ready, 0);
            @(posedge clk);
            #2;
        end
        out_ready = 1'b1;
    endtask

    task automatic sendFrame(input int v, input int stall_at, input int bubble_at);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int         idx;
                int         m;
                logic [7:0] pix;
                idx = r * W + c;
                if (vecs[v].row_step) pix = (r < 2) ? vecs[v].a : vecs[v].b;
                else                  pix = (c < 4) ? vecs[v].a : vecs[v].b;
                m = (r >= 2 && vecs[v].mask[c]) ? int'(vecs[v].mag) : 0;
                if (idx == bubble_at) begin
                    in_valid  = 1'b0;
                    out_ready = 1'b1;
                    repeat (2) begin
                        @(posedge clk);
                        #2;
                    end
                end
                if (idx == stall_at) stallCycles(pix, 5);
                applyStimulus(pix, expOut(m));
            end
        end
    endtask

    initial begin
        int waited;
        in_valid  = 1'b0;
        in_pixel  = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;

        vecs[0] = '{1'b0, 8'd100, 8'd100, 16'd0,    8'h00};
        vecs[1] = '{1'b0, 8'd0,   8'd10,  16'd40,   8'h30};
        vecs[2] = '{1'b0, 8'd0,   8'd255, 16'd1020, 8'h30};
        vecs[3] = '{1'b0, 8'd10,  8'd0,   16'd40,   8'h30};
        vecs[4] = '{1'b0, 8'd0,   8'd15,  16'd60,   8'h30};
        vecs[5] = '{1'b1, 8'd0,   8'd20,  16'd80,   8'hFC};
        vecs[6] = '{1'b1, 8'd200, 8'd0,   16'd800,  8'hFC};

        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_pixel", out_pixel, 0);
        checkOutput("reset in_ready", in_ready, 1);
        @(posedge clk);
        #2;

        for (int v = 0; v < 7; v++) sendFrame(v, -1, -1);
        checkOutput("first output latency (edges)", first_valid_edge - first_xfer_edge, 2);

        $display("[TB] step frame with bubble and 5-cycle output stall");
        sendFrame(1, 20, 10);

        $display("[TB] reset after 13 transfers of a 0->255 frame");
        for (int i = 0; i < 13; i++) applyStimulus(((i % W) < 4) ? 8'd0 : 8'd255, 8'd0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        expq.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("out_valid after mid-frame reset", out_valid, 0);
        checkOutput("in_ready after mid-frame reset", in_ready, 1);
        @(posedge clk);
        #2;
        sendFrame(0, -1, -1);

        in_valid = 1'b0;
        waited   = 0;
        while (expq.size() > 0 && waited < 20) begin
            @(posedge clk);
            #2;
            waited++;
        end
        checkOutput("outputs drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
